saturate: RTL and testbench
===========================

// Module: saturate
// PURPOSE
//   Streaming signed-saturation stage: narrows a two's-complement ARGW-bit
//   argument to RESW bits, clamping to the largest/smallest representable
//   result instead of wrapping. Sits at the output of wide accumulators and
//   multipliers in the datapath, ahead of fixed-width storage and links.
//   Uses a valid/ready handshake on both sides with one registered stage.
// PARAMETERS
//   ARGW  24  argument width in bits, signed; must satisfy ARGW >= RESW
//   RESW  16  result width in bits, signed; must satisfy RESW >= 2
// PORTS
//   clk        in   1     clock, all state on rising edge
//   rst_n      in   1     asynchronous active-low reset
//   arg_valid  in   1     argument valid
//   arg_ready  out  1     stage can accept argument this cycle
//   arg_data   in   ARGW  signed argument
//   res_valid  out  1     result valid
//   res_ready  in   1     downstream accepts result this cycle
//   res_data   out  RESW  signed saturated result
// BEHAVIOUR
//   Reset (rst_n=0, async assert, sync release): res_valid=0, res_data=0.
//     arg_ready=1 while the stage is empty.
//   Handshake:
//     - A transfer occurs on a rising edge where valid&&ready on that side.
//     - arg_ready = !res_valid || res_ready (combinational; no comb path
//       from arg_valid to arg_ready).
//     - On an arg transfer: res_data <= sat(arg_data), res_valid <= 1.
//     - On a res transfer with no arg transfer: res_valid <= 0; res_data
//       holds its last value.
//     - Simultaneous res and arg transfer: new result loaded, res_valid
//       stays 1 (full throughput, one result per cycle).
//     - While res_valid=1 && res_ready=0, res_data and res_valid are held
//       stable.
//   Latency: result valid on the cycle after the arg transfer edge.
//   Arithmetic, with MAX = 2^(RESW-1)-1 and MIN = -2^(RESW-1):
//     - arg > MAX          -> MAX (16'h7fff at default widths)
//     - arg < MIN          -> MIN (16'h8000 at default widths)
//     - otherwise          -> arg[RESW-1:0] (exact, sign preserved)
//     - Overflow detection: bits arg[ARGW-1:RESW-1] are not all equal;
//       the sign bit arg[ARGW-1] selects MAX (0) or MIN (1).
//     - ARGW == RESW: pass-through, never saturates.
//   Reset mid-operation: pending result is dropped, res_valid=0
//     immediately; the first transfer after release behaves as from reset.
// TESTING
//   arg 24'h0000ff -> res 16'h00ff one cycle later, res_valid=1.
//   arg 24'hffff00 (-256) -> res 16'hff00 (in range, sign kept).
//   arg 24'h7fffff -> res 16'h7fff; arg 24'h008000 -> 16'h7fff
//     (positive clamp, including the smallest overflowing value).
//   arg 24'h800000 -> res 16'h8000; arg 24'hff7fff -> 16'h8000
//     (negative clamp); arg 24'hff8000 -> 16'h8000 exact.
//   Backpressure: hold res_ready=0 with a result pending -> arg_ready=0,
//     res_data stable; then stream 4 args back-to-back with res_ready=1
//     -> 4 results on consecutive cycles in order.
//   Pulse rst_n low with a result pending -> res_valid=0 at once; rerun
//     all vectors above after release with identical results.

Source files
------------

// File: rtl/saturate.sv
// +---------------------------------------------------------------------------+
// | saturate: one-stage valid/ready signed saturation from ARGW to RESW bits  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module saturate #(
  parameter int ARGW = 24,
  parameter int RESW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            arg_valid,
  output logic            arg_ready,
  input  logic [ARGW-1:0] arg_data,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [RESW-1:0] res_data
);

  localparam logic [RESW-1:0] C_MAX = {1'b0, {(RESW-1){1'b1}}};
  localparam logic [RESW-1:0] C_MIN = {1'b1, {(RESW-1){1'b0}}};

  logic            res_valid_q, res_valid_d;
  logic [RESW-1:0] res_data_q, res_data_d;
  logic [RESW-1:0] w_sat;
  logic            w_arg_xfer;

  generate
    if (ARGW == RESW) begin : g_pass
      assign w_sat = arg_data;
    end else begin : g_sat
      // Argument fits only when every bit from the result sign upward agrees.
      logic [ARGW-RESW:0] w_top;
      logic               w_ovf;
      assign w_top = arg_data[ARGW-1:RESW-1];
      assign w_ovf = !((&w_top) || !(|w_top));
      assign w_sat = w_ovf ? (arg_data[ARGW-1] ? C_MIN : C_MAX)
                           : arg_data[RESW-1:0];
    end
  endgenerate

  always_comb begin
    arg_ready   = !res_valid_q || res_ready;
    w_arg_xfer  = arg_valid && arg_ready;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    if (w_arg_xfer) begin
      res_valid_d = 1'b1;
      res_data_d  = w_sat;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule

`default_nettype wire

// File: tb/tb_saturate.sv
// +---------------------------------------------------------------------------+
// | tb_saturate: randomized and directed checks against a saturation model    |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_saturate;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arg_valid = 1'b0;
  logic        arg_ready;
  logic [23:0] arg_data = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;

  int checks = 0;
  int failures = 0;
  logic [15:0] pend[$];

  saturate #(.ARGW(24), .RESW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arg_valid (arg_valid),
    .arg_ready (arg_ready),
    .arg_data  (arg_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sat(input logic [23:0] a);
    longint v;
    v = longint'($signed(a));
    if (v > 32767)  return 16'h7fff;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs just after an edge, check ready, clock, check outputs.
  task automatic cycle(input logic av, input logic [23:0] ad, input logic rr);
    logic exp_ready, acc, out;
    arg_valid = av;
    arg_data  = ad;
    res_ready = rr;
    #1;
    exp_ready = (pend.size() == 0) || rr;
    chk("arg_ready", {31'd0, arg_ready}, {31'd0, exp_ready});
    acc = av && exp_ready;
    out = (pend.size() != 0) && rr;
    if (out) void'(pend.pop_front());
    @(posedge clk);
    #1;
    if (acc) pend.push_back(sat(ad));
    chk("res_valid", {31'd0, res_valid}, {31'd0, pend.size() != 0});
    if (pend.size() != 0) chk("res_data", {16'd0, res_data}, {16'd0, pend[0]});
  endtask

  task automatic vectors();
    logic [23:0] v[7];
    v = '{24'h0000ff, 24'hffff00, 24'h7fffff, 24'h008000,
          24'h800000, 24'hff7fff, 24'hff8000};
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, v[i], 1'b1);
      chk("vec_value", {16'd0, res_data}, {16'd0, sat(v[i])});
    end
    cycle(1'b0, 24'd0, 1'b1);
  endtask

  function automatic logic [23:0] rand_arg();
    case ($urandom_range(0, 3))
      0:       return $urandom_range(0, 32767) - 24'd16384;
      1:       return 24'h008000 + $urandom_range(0, 3) - 24'd2;
      2:       return 24'hff8000 + $urandom_range(0, 3) - 24'd2;
      default: return 24'($urandom);
    endcase
  endfunction

  initial begin
    #2;
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_data", {16'd0, res_data}, 32'd0);
    chk("rst_ready", {31'd0, arg_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    vectors();
    chk("spec_exact_max", {16'd0, sat(24'h007fff)}, 32'h7fff);

    // Backpressure: load one result, stall with new args offered.
    cycle(1'b1, 24'h001234, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 24'h000777, 1'b0);
    chk("stall_data", {16'd0, res_data}, 32'h1234);
    for (int i = 0; i < 4; i++) cycle(1'b1, 24'h000100 + 24'(i), 1'b1);
    chk("stream_last", {16'd0, res_data}, 32'h0103);
    cycle(1'b0, 24'd0, 1'b1);

    // Reset with a result pending.
    cycle(1'b1, 24'h7fffff, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    pend.delete();
    chk("midrst_valid", {31'd0, res_valid}, 32'd0);
    chk("midrst_ready", {31'd0, arg_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors();

    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 3) != 0), rand_arg(), 1'($urandom_range(0, 3) != 0));
    cycle(1'b0, 24'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
